// File: rtl/apb_bridge_fsm.sv
// AHB-to-APB bridge: decodes NSLV equal-size slave windows and runs APB SETUP/ACCESS
// with per-slave wait states, slave-error propagation and a wait-state timeout.
module apb_bridge_fsm #(
    parameter int                NSLV      = 7,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0400,
    parameter logic [ADDR_W-1:0] SLV_SIZE  = 32'h400,
    parameter int                TIMEOUT   = 255
) (
    input  logic                   pclk,
    input  logic                   hreset,
    input  logic                   hsel,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [ADDR_W-1:0]      haddr,
    input  logic [DATA_W-1:0]      hwdata,
    input  logic                   hreadyin,
    output logic                   hreadyout,
    output logic [1:0]             hresp,
    output logic [DATA_W-1:0]      hrdata,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDR_W-1:0]      paddr,
    output logic [DATA_W-1:0]      pwdata,
    input  logic [NSLV*DATA_W-1:0] prdata_bus,
    input  logic [NSLV-1:0]        pready,
    input  logic [NSLV-1:0]        pslverr
);

    localparam int SHIFT = $clog2(SLV_SIZE);
    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LATCH  = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] ACCESS = 3'd3;
    localparam logic [2:0] ERR1   = 3'd4;
    localparam logic [2:0] ERR2   = 3'd5;

    logic [2:0]        st, st_nxt;
    logic [IDX_W-1:0]  idx, dec_idx;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] off;
    logic              accept, take, mapped;
    logic              rdy_sel, err_sel;
    logic [DATA_W-1:0] prd_sel;
    logic [NSLV-1:0]   sel_onehot;
    logic              unused_htrans0;

    // NONSEQ and SEQ are handled alike, so the low htrans bit carries no information here
    assign unused_htrans0 = htrans[0];

    assign accept  = hsel & hreadyin & htrans[1];
    assign take    = accept & ((st == IDLE) | (st == ERR2));
    // Offset below BASE_ADDR wraps to a huge value, so the window check needs both bounds
    assign off     = (haddr - BASE_ADDR) >> SHIFT;
    assign mapped  = (haddr >= BASE_ADDR) && (off < ADDR_W'(NSLV));
    assign dec_idx = off[IDX_W-1:0];

    always_comb begin
        rdy_sel    = 1'b0;
        err_sel    = 1'b0;
        prd_sel    = '0;
        sel_onehot = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx == IDX_W'(i)) begin
                rdy_sel       = pready[i];
                err_sel       = pslverr[i];
                prd_sel       = prdata_bus[i*DATA_W +: DATA_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (accept) st_nxt = mapped ? LATCH : ERR1;
            LATCH:   st_nxt = SETUP;
            SETUP:   st_nxt = ACCESS;
            ACCESS: begin
                if (rdy_sel)
                    st_nxt = err_sel ? ERR1 : IDLE;
                else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1)))
                    st_nxt = ERR1;
            end
            ERR1:    st_nxt = ERR2;
            ERR2:    st_nxt = accept ? (mapped ? LATCH : ERR1) : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they change cleanly on the edge
    always_ff @(posedge pclk) begin
        if (hreset) begin
            st        <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            hrdata    <= '0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            st        <= st_nxt;
            hreadyout <= (st_nxt == IDLE) || (st_nxt == ERR2);
            hresp     <= ((st_nxt == ERR1) || (st_nxt == ERR2)) ? 2'b01 : 2'b00;
            psel      <= ((st_nxt == SETUP) || (st_nxt == ACCESS)) ? sel_onehot : '0;
            penable   <= (st_nxt == ACCESS);
            if (take) begin
                paddr  <= haddr;
                pwrite <= hwrite;
                idx    <= dec_idx;
            end
            if (st == LATCH)
                pwdata <= hwdata;
            if (st == SETUP)
                cnt <= '0;
            else if ((st == ACCESS) && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + CNT_W'(1);
            if ((st == ACCESS) && rdy_sel && !err_sel && !pwrite)
                hrdata <= prd_sel;
        end
    end

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Directed bench for apb_bridge_fsm: table of single transfers plus hand-written
// sequences for ERROR back-to-back accept, reset during ACCESS and idle/busy cycles.
module tb_apb_bridge_fsm;

    localparam int NSLV = 7;

    logic             pclk = 1'b0;
    logic             hreset;
    logic             hsel;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [31:0]      haddr;
    logic [31:0]      hwdata;
    logic             hreadyin;
    logic             hreadyout;
    logic [1:0]       hresp;
    logic [31:0]      hrdata;
    logic [NSLV-1:0]  psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      paddr;
    logic [31:0]      pwdata;
    logic [NSLV*32-1:0] prdata_bus;
    logic [NSLV-1:0]  pready;
    logic [NSLV-1:0]  pslverr;

    int          checks = 0;
    int          failures = 0;
    int          tslv = 0;
    int          wait_cfg = 0;
    logic        err_cfg = 1'b0;
    logic [31:0] rdata_cfg = '0;
    int          acc_cnt = 0;

    apb_bridge_fsm #(.NSLV(NSLV), .TIMEOUT(4)) dut (
        .pclk(pclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hwdata(hwdata), .hreadyin(hreadyin), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata_bus(prdata_bus), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave model: the target slave waits wait_cfg ACCESS cycles; every other slave
    // drives ready and error high so any leakage from unselected slaves shows up.
    always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

    always_comb begin
        pready  = '1;
        pslverr = '1;
        for (int i = 0; i < NSLV; i++) prdata_bus[i*32 +: 32] = 32'hBAD0_0000 | i;
        pready[tslv]  = (acc_cnt >= wait_cfg);
        pslverr[tslv] = err_cfg;
        prdata_bus[tslv*32 +: 32] = rdata_cfg;
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          slv;
        int          wt;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        logic [1:0]  resp;
        logic [31:0] hrd;
        logic [6:0]  psel_exp;
        int          pen;
        logic        mapped;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                input int s, input int wt, input logic e, input logic [31:0] rd,
                                input int c, input logic [1:0] r, input logic [31:0] h,
                                input logic [6:0] ps, input int pn, input logic m);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = wd; v.slv = s; v.wt = wt; v.err = e; v.rdata = rd;
        v.cyc = c; v.resp = r; v.hrd = h; v.psel_exp = ps; v.pen = pn; v.mapped = m;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           output int ncyc, output logic [1:0] resp, output logic [6:0] psel_or,
                           output int pen_n, output logic lo_err);
        ncyc = 0; resp = 2'b11; psel_or = '0; pen_n = 0; lo_err = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w;
        step();
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        for (int n = 1; n <= 40; n++) begin
            psel_or |= psel;
            if (penable) pen_n++;
            if (hreadyout) begin
                ncyc = n;
                resp = hresp;
                break;
            end
            if (hresp == 2'b01) lo_err = 1'b1;
            step();
        end
    endtask

    initial begin
        int          ncyc, pen_n;
        logic [1:0]  resp;
        logic [6:0]  psel_or;
        logic        lo_err;
        bit          got;

        vt[0]  = mk(32'h4000_0C10, 1, 32'hA5A5_0001, 2, 0,   0, 32'h0,         4, 2'b00, 32'h0,         7'b0000100, 1, 1);
        vt[1]  = mk(32'h4000_1C00, 0, 32'h0,         6, 3,   0, 32'hDEAD_BEEF, 7, 2'b00, 32'hDEAD_BEEF, 7'b1000000, 4, 1);
        vt[2]  = mk(32'h4000_0000, 0, 32'h0,         0, 0,   0, 32'h1111_1111, 2, 2'b01, 32'hDEAD_BEEF, 7'b0000000, 0, 0);
        vt[3]  = mk(32'h4000_0400, 0, 32'h0,         0, 0,   1, 32'h2222_2222, 5, 2'b01, 32'hDEAD_BEEF, 7'b0000001, 1, 1);
        vt[4]  = mk(32'h4000_0FFC, 0, 32'h0,         2, 1,   0, 32'h1234_5678, 5, 2'b00, 32'h1234_5678, 7'b0000100, 2, 1);
        vt[5]  = mk(32'h4000_1800, 1, 32'h0BAD_F00D, 5, 2,   0, 32'h3333_3333, 6, 2'b00, 32'h1234_5678, 7'b0100000, 3, 1);
        vt[6]  = mk(32'h4000_2000, 0, 32'h0,         0, 0,   0, 32'h0,         2, 2'b01, 32'h1234_5678, 7'b0000000, 0, 0);
        vt[7]  = mk(32'h4000_03FC, 0, 32'h0,         0, 0,   0, 32'h0,         2, 2'b01, 32'h1234_5678, 7'b0000000, 0, 0);
        vt[8]  = mk(32'h4000_1FFC, 0, 32'h0,         6, 0,   0, 32'hCAFE_F00D, 4, 2'b00, 32'hCAFE_F00D, 7'b1000000, 1, 1);
        vt[9]  = mk(32'h4000_1000, 0, 32'h0,         3, 100, 0, 32'h4444_4444, 8, 2'b01, 32'hCAFE_F00D, 7'b0001000, 4, 1);
        vt[10] = mk(32'h4000_1004, 1, 32'h5A5A_5A5A, 3, 0,   0, 32'h0,         4, 2'b00, 32'hCAFE_F00D, 7'b0001000, 1, 1);

        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = '0; hwdata = '0; hreadyin = 1'b1;
        step(); step();
        hreset = 1'b0;
        chk("rst_hreadyout", hreadyout, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_hrdata", hrdata, 0);
        step();

        for (int i = 0; i < 11; i++) begin
            tslv = vt[i].slv; wait_cfg = vt[i].wt; err_cfg = vt[i].err; rdata_cfg = vt[i].rdata;
            do_xfer(vt[i].addr, vt[i].wr, vt[i].wdata, ncyc, resp, psel_or, pen_n, lo_err);
            chk($sformatf("v%0d_cycles", i), ncyc, vt[i].cyc);
            chk($sformatf("v%0d_hresp", i), resp, vt[i].resp);
            chk($sformatf("v%0d_hrdata", i), hrdata, vt[i].hrd);
            chk($sformatf("v%0d_psel", i), psel_or, vt[i].psel_exp);
            chk($sformatf("v%0d_penable_cycles", i), pen_n, vt[i].pen);
            chk($sformatf("v%0d_err_first_phase", i), lo_err, vt[i].resp == 2'b01);
            if (vt[i].mapped) begin
                chk($sformatf("v%0d_paddr", i), paddr, vt[i].addr);
                chk($sformatf("v%0d_pwrite", i), pwrite, vt[i].wr);
                chk($sformatf("v%0d_pwdata", i), pwdata, vt[i].wdata);
            end
            step();
        end

        // Unmapped read followed by an accept during the second ERROR cycle
        tslv = 1; wait_cfg = 0; err_cfg = 0; rdata_cfg = 32'h7777_0001;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0000; hwrite = 1'b0;
        step();
        hsel = 1'b0; htrans = 2'b00;
        chk("b2b_c1_hreadyout", hreadyout, 0);
        chk("b2b_c1_hresp", hresp, 2'b01);
        chk("b2b_c1_psel", psel, 0);
        step();
        chk("b2b_c2_hreadyout", hreadyout, 1);
        chk("b2b_c2_hresp", hresp, 2'b01);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0800; hwrite = 1'b1;
        step();
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0F0F_1234;
        chk("b2b_c3_hreadyout", hreadyout, 0);
        chk("b2b_c3_hresp", hresp, 0);
        chk("b2b_c3_psel", psel, 0);
        step();
        chk("b2b_c4_psel", psel, 7'b0000010);
        chk("b2b_c4_penable", penable, 0);
        step();
        chk("b2b_c5_penable", penable, 1);
        step();
        chk("b2b_c6_hreadyout", hreadyout, 1);
        chk("b2b_c6_hresp", hresp, 0);
        chk("b2b_c6_psel", psel, 0);
        chk("b2b_pwdata", pwdata, 32'h0F0F_1234);
        chk("b2b_paddr", paddr, 32'h4000_0800);
        step();

        // Reset in the middle of an ACCESS phase of a write
        tslv = 4; wait_cfg = 100; err_cfg = 0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_1400; hwrite = 1'b1;
        step();
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1357_9BDF;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (penable) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("rstmid_reached_access", got, 1);
        chk("rstmid_psel_before", psel, 7'b0010000);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        chk("rstmid_psel", psel, 0);
        chk("rstmid_penable", penable, 0);
        chk("rstmid_hreadyout", hreadyout, 1);
        chk("rstmid_hresp", hresp, 0);
        chk("rstmid_hrdata", hrdata, 0);
        chk("rstmid_paddr", paddr, 0);

        // IDLE and BUSY transfers, and a NONSEQ without hsel, are zero-wait OKAY
        tslv = 0; wait_cfg = 0;
        for (int k = 0; k < 3; k++) begin
            hsel = (k != 2); htrans = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10);
            haddr = 32'h4000_0400;
            step();
            chk($sformatf("noxfer%0d_hreadyout", k), hreadyout, 1);
            chk($sformatf("noxfer%0d_hresp", k), hresp, 0);
            chk($sformatf("noxfer%0d_psel", k), psel, 0);
            chk($sformatf("noxfer%0d_paddr", k), paddr, 0);
        end
        hsel = 1'b0; htrans = 2'b00;
        step();
        chk("noxfer_tail_psel", psel, 0);
        chk("noxfer_tail_penable", penable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_bridge_fsm.md
Name: apb_bridge_fsm

Overview:
Parametrised AHB-to-APB bridge with a full APB protocol state machine: SETUP/ACCESS sequencing, per-slave PREADY wait states, PSLVERR propagation and a wait-state timeout. It is the next generation of the AHB-side decoder. It has a generic slave count and address map, real HREADYOUT stalling, and a two-cycle AHB ERROR response for unmapped addresses and slave errors. It sits between the AHB interconnect (as an AHB slave) and NSLV APB peripherals.

Parameters:
NSLV, 7, number of APB slaves (1..16).
ADDR_W, 32, address width.
DATA_W, 32, data width.
BASE_ADDR, 32'h4000_0400, base of slave 0 window.
SLV_SIZE, 32'h400, window size per slave; power of two; slave i spans BASE_ADDR+i*SLV_SIZE .. BASE_ADDR+(i+1)*SLV_SIZE-1.
TIMEOUT, 255, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
pclk  in  1  clock
hreset  in  1  synchronous reset, active-high
hsel  in  1  AHB slave select
htrans  in  2  AHB transfer type
hwrite  in  1  AHB write
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data (data phase)
hreadyin  in  1  AHB bus ready
hreadyout  out  1  bridge ready
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DATA_W  read data
psel  out  NSLV  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata_bus  in  NSLV*DATA_W  concatenated slave read data; slave i at [i*DATA_W +: DATA_W]
pready  in  NSLV  per-slave ready
pslverr  in  NSLV  per-slave error

Behaviour:
- Reset (sampled at posedge pclk while hreset=1):
  - state IDLE; hreadyout=1; hresp=00; psel=0; penable=0.
  - pwrite, paddr, pwdata, hrdata, timeout counter all 0.
  - Reset mid-transfer aborts it at the same edge; no completion, no error is reported.
- Transfer accept condition: state IDLE or ERR2, and hsel & hreadyin & htrans[1]. NONSEQ and SEQ are treated identically.
- IDLE and BUSY transfers, and cycles with hsel=0, produce a zero-wait OKAY (hreadyout=1, hresp=00).
- Decode:
  - Mapped when BASE_ADDR <= haddr < BASE_ADDR+NSLV*SLV_SIZE.
  - Slave index = (haddr-BASE_ADDR)>>log2(SLV_SIZE).
  - On accept, paddr<=haddr, pwrite<=hwrite, and the index is registered.
- States and transitions:
  - IDLE: hreadyout=1, hresp=00.
    - accept & mapped -> LATCH
    - accept & unmapped -> ERR1
    - otherwise stay
  - LATCH: hreadyout=0; pwdata<=hwdata at the exiting edge, captured for reads too; -> SETUP.
  - SETUP: psel[idx]=1, penable=0, hreadyout=0; -> ACCESS; timeout counter cleared.
  - ACCESS: psel[idx]=1, penable=1, hreadyout=0; counter increments each cycle.
    - pready[idx] & !pslverr[idx]: if read, hrdata<=prdata_bus slice; -> IDLE.
    - pready[idx] & pslverr[idx]: -> ERR1; hrdata unchanged.
    - !pready[idx] & TIMEOUT!=0 & counter==TIMEOUT-1: -> ERR1 (abort).
  - ERR1: psel=0, penable=0, hreadyout=0, hresp=01; -> ERR2.
  - ERR2: hreadyout=1, hresp=01.
    - accept behaves as in IDLE (-> LATCH or ERR1).
    - otherwise -> IDLE.
- Outputs hreadyout, hresp, psel and penable are registered, decoded from state plus registered index.
- psel and penable are cleared in the cycle after ACCESS completion.
- Latency, zero-wait slave: address phase at cycle 0; hreadyout=0 for cycles 1..3; hreadyout=1 with OKAY in cycle 4. Each pready wait cycle adds one cycle.
- Unmapped address: ERROR in cycles 1 (hreadyout=0) and 2 (hreadyout=1); no APB activity.
- paddr, pwrite and pwdata hold their values until the next accept/LATCH.
- Inputs pready and pslverr from unselected slaves are ignored.
- hrdata holds the last successful read value; writes do not change it.
- Timeout counter width is clog2(TIMEOUT+1) and saturates; it has no effect when TIMEOUT=0.

Test Plan:
- Reset then write 32'hA5A5_0001 to 32'h4000_0C10, slave 2 pready tied 1 -> psel=7'b0000100 in cycles 2-3, penable=1 in cycle 3, paddr=32'h4000_0C10, pwdata=32'hA5A5_0001, pwrite=1, hreadyout=1/OKAY in cycle 4.
- Read 32'h4000_1C00 with slave 6 giving prdata=32'hDEAD_BEEF and pready low for 3 ACCESS cycles -> hreadyout low for cycles 1..6, hrdata=32'hDEAD_BEEF with OKAY in cycle 7.
- Read 32'h4000_0000 (unmapped) -> psel stays 0; hresp=01 with hreadyout=0 in cycle 1; hresp=01 with hreadyout=1 in cycle 2; back-to-back accept in cycle 2 proceeds to LATCH.
- Slave 0 returns pready=1, pslverr=1 on a read -> two-cycle ERROR response, hrdata unchanged from the previous value.
- TIMEOUT=4, slave 3 pready held 0 -> penable high exactly 4 cycles, then psel=0 and ERROR sequence; a subsequent write to slave 3 with pready=1 completes OKAY.
- hreset asserted in ACCESS mid-write -> next cycle psel=0, penable=0, hreadyout=1, hresp=00, hrdata=0; htrans=IDLE with hsel=1 -> zero-wait OKAY with no APB activity.
